// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB low/full-speed packet transmitter.
// Line states are encoded as {d_plus, d_minus}.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_PID     = 3'd2,
        ST_DATA    = 3'd3,
        ST_EOP_SE0 = 3'd4,
        ST_EOP_J   = 3'd5
    } state_e;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_tx_encoder.sv
// NRZI line encoder with bit stuffing. Each bit_valid_i starts a new bit slot;
// when six ones have just gone out, that slot carries a stuffed 0 instead of bit_in_i.
module usb_tx_encoder
    import usb_tx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       bit_valid_i,
    input  logic       bit_in_i,
    input  logic       se0_i,
    output logic       stuff_stall_o,
    output logic [1:0] line_o
);

    logic [1:0] nrzi_q, nrzi_d;
    logic [1:0] line_q, line_d;
    logic [2:0] ones_q, ones_d;
    logic [1:0] toggled_s;

    assign stuff_stall_o = (ones_q == STUFF_LIMIT);
    assign toggled_s     = (nrzi_q == J) ? K : J;
    assign line_o        = line_q;

    // Next line level, NRZI state and ones count for the slot being started
    always_comb begin
        nrzi_d = nrzi_q;
        line_d = line_q;
        ones_d = ones_q;
        if (bit_valid_i) begin
            if (se0_i) begin
                nrzi_d = J;
                line_d = SE0;
                ones_d = 3'd0;
            end else if (stuff_stall_o || !bit_in_i) begin
                nrzi_d = toggled_s;
                line_d = toggled_s;
                ones_d = 3'd0;
            end else begin
                line_d = nrzi_q;
                ones_d = ones_q + 3'd1;
            end
        end else begin
            nrzi_d = nrzi_q;
        end
    end

    // Encoder state registers; reset leaves the line idle at J
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nrzi_q <= J;
            line_q <= J;
            ones_q <= 3'd0;
        end else begin
            nrzi_q <= nrzi_d;
            line_q <= line_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/usb_tx.sv
// USB packet transmitter: SYNC, PID, payload bytes from a show-ahead FIFO, then EOP.
// The FSM state always describes the bit slot currently on the lines.
module usb_tx
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [7:0] tx_data,
    input  logic       tx_empty,
    output logic       tx_r_enable,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_CLK  = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] CLK_ONE  = CW'(1);

    state_e      state_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [3:0]  pid_q;
    logic        busy_q;
    logic        done_q;
    logic        pop_q;

    logic        slot_end_s;
    logic        in_byte_s;
    logic        stuff_stall_s;
    logic        enc_valid_s;
    logic        enc_bit_s;
    logic        enc_se0_s;
    logic [1:0]  line_s;

    assign slot_end_s  = (clk_cnt_q == LAST_CLK);
    assign in_byte_s   = (state_q == ST_PID) || (state_q == ST_DATA);
    assign tx_r_enable = pop_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign d_plus      = line_s[1];
    assign d_minus     = line_s[0];

    // Select what the encoder emits in the bit slot that starts on the next edge
    always_comb begin
        enc_valid_s = 1'b0;
        enc_bit_s   = 1'b1;
        enc_se0_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    enc_valid_s = 1'b1;
                    enc_bit_s   = SYNC_BYTE[0];
                end else begin
                    enc_valid_s = 1'b0;
                end
            end
            ST_SYNC, ST_PID, ST_DATA: begin
                if (slot_end_s) begin
                    enc_valid_s = 1'b1;
                    if (stuff_stall_s) begin
                        enc_bit_s = 1'b0;
                    end else if (bit_cnt_q != 3'd7) begin
                        enc_bit_s = shift_q[1];
                    end else if (state_q == ST_SYNC) begin
                        enc_bit_s = pid_q[0];
                    end else if (pop_q) begin
                        enc_bit_s = tx_data[0];
                    end else begin
                        enc_se0_s = 1'b1;
                    end
                end else begin
                    enc_valid_s = 1'b0;
                end
            end
            ST_EOP_SE0: begin
                if (slot_end_s) begin
                    enc_valid_s = 1'b1;
                    enc_se0_s   = (bit_cnt_q == 3'd0);
                end else begin
                    enc_valid_s = 1'b0;
                end
            end
            default: begin
                enc_valid_s = 1'b0;
            end
        endcase
    end

    // Packet sequencer with registered pop/done/busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            pid_q     <= 4'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pop_q     <= 1'b0;
        end else begin
            // Pop is decided one cycle early so it is high in the byte's final cycle
            pop_q  <= in_byte_s && (clk_cnt_q == PRE_CLK) && (bit_cnt_q == 3'd7)
                      && !stuff_stall_s && !tx_empty;
            done_q <= (state_q == ST_EOP_J) && (clk_cnt_q == PRE_CLK);
            case (state_q)
                ST_IDLE: begin
                    if (tx_start) begin
                        state_q   <= ST_SYNC;
                        pid_q     <= tx_pid;
                        shift_q   <= SYNC_BYTE;
                        bit_cnt_q <= 3'd0;
                        clk_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end else begin
                        clk_cnt_q <= '0;
                    end
                end
                ST_SYNC, ST_PID, ST_DATA: begin
                    if (!slot_end_s) begin
                        clk_cnt_q <= clk_cnt_q + CLK_ONE;
                    end else begin
                        clk_cnt_q <= '0;
                        if (stuff_stall_s) begin
                            bit_cnt_q <= bit_cnt_q;
                        end else if (bit_cnt_q != 3'd7) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end else begin
                            bit_cnt_q <= 3'd0;
                            if (state_q == ST_SYNC) begin
                                state_q <= ST_PID;
                                shift_q <= pid_byte(pid_q);
                            end else if (pop_q) begin
                                state_q <= ST_DATA;
                                shift_q <= tx_data;
                            end else begin
                                state_q <= ST_EOP_SE0;
                            end
                        end
                    end
                end
                ST_EOP_SE0: begin
                    if (!slot_end_s) begin
                        clk_cnt_q <= clk_cnt_q + CLK_ONE;
                    end else if (bit_cnt_q == 3'd0) begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= 3'd1;
                    end else begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= 3'd0;
                        state_q   <= ST_EOP_J;
                    end
                end
                ST_EOP_J: begin
                    if (!slot_end_s) begin
                        clk_cnt_q <= clk_cnt_q + CLK_ONE;
                    end else begin
                        clk_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    usb_tx_encoder u_encoder (
        .clk_i         (clk),
        .rst_i         (rst),
        .bit_valid_i   (enc_valid_s),
        .bit_in_i      (enc_bit_s),
        .se0_i         (enc_se0_s),
        .stuff_stall_o (stuff_stall_s),
        .line_o        (line_s)
    );

endmodule

// File: tb/tb_usb_tx.sv
// Scoreboard bench for usb_tx: a behavioural NRZI receiver decodes the lines and
// compares each byte against bytes queued when the packet was launched.
module tb_usb_tx;

    localparam int CPB = 8;
    localparam logic [1:0] LJ = 2'b10;
    localparam logic [1:0] LK = 2'b01;
    localparam logic [1:0] LS = 2'b00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [3:0] tx_pid = 4'h0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_empty = 1'b1;
    logic       tx_r_enable, d_plus, d_minus, tx_busy, tx_done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int cyc = 0;
    int pop_cnt = 0;
    int pop_cyc[$];

    logic       rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [1:0] rx_prev = 2'b10;
    int         rx_ones = 0;
    int         rx_nb = 0;
    logic [7:0] rx_sh = 8'h00;
    int         rx_stuffs = 0;
    int         rx_errs = 0;

    usb_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid),
        .tx_data(tx_data), .tx_empty(tx_empty), .tx_r_enable(tx_r_enable),
        .d_plus(d_plus), .d_minus(d_minus), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // FIFO model: pops on the edge where tx_r_enable is high
    always @(posedge clk) begin
        cyc++;
        if (tx_r_enable) begin
            pop_cnt++;
            pop_cyc.push_back(cyc);
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
    end

    always @(negedge clk) begin
        tx_empty = (fifo_q.size() == 0);
        tx_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    end

    task automatic rx_sample(input logic [1:0] ln);
        logic b;
        logic [7:0] e;
        if (ln == LS) begin
            if (rx_nb != 0) rx_errs++;
            rx_on = 1'b0;
        end else begin
            b = (ln == rx_prev);
            rx_prev = ln;
            if (rx_ones == 6) begin
                if (b) rx_errs++;
                else rx_stuffs++;
                rx_ones = 0;
            end else begin
                rx_ones = b ? rx_ones + 1 : 0;
                rx_sh = {b, rx_sh[7:1]};
                rx_nb++;
                if (rx_nb == 8) begin
                    rx_nb = 0;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL rx_byte: got %h, no byte expected", rx_sh);
                    end else begin
                        e = exp_q.pop_front();
                        if (rx_sh !== e) begin
                            miscompares++;
                            $display("FAIL rx_byte: got %h, required %h", rx_sh, e);
                        end
                    end
                end
            end
        end
    endtask

    // Receiver: starts on the first K after idle, samples once per bit time
    always @(negedge clk) begin
        if (rst) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if ({d_plus, d_minus} == LK) begin
                rx_on = 1'b1; rx_cnt = 0; rx_prev = LJ; rx_ones = 0; rx_nb = 0;
                rx_sample({d_plus, d_minus});
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == CPB) begin
                rx_cnt = 0;
                rx_sample({d_plus, d_minus});
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({d_plus, d_minus, tx_busy, tx_done, tx_r_enable} !== {LJ, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_state: got %b, required %b",
                     {d_plus, d_minus, tx_busy, tx_done, tx_r_enable}, {LJ, 3'b000});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_lines;
        logic [1:0] el [19];
        el = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LK, LJ, LK, LJ, LK, LK, LK, LK, LS, LS, LJ};
        fifo_q.delete();
        pop_cnt = 0;
        repeat (2) @(negedge clk);
        tx_pid = 4'b0001; tx_start = 1'b1;
        exp_q.push_back(8'h80); exp_q.push_back(8'hE1);
        @(negedge clk);
        tx_start = 1'b0;
        for (int n = 1; n <= 152; n++) begin
            if (n > 1) @(negedge clk);
            vectors++;
            if ({d_plus, d_minus} !== el[(n-1)/CPB] || tx_done !== (n == 152) || tx_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_line cyc %0d: got line=%b done=%b busy=%b, required line=%b done=%b busy=1",
                         n, {d_plus, d_minus}, tx_done, tx_busy, el[(n-1)/CPB], (n == 152));
            end
        end
        @(negedge clk);
        vectors++;
        if ({d_plus, d_minus, tx_busy, tx_done} !== {LJ, 2'b00} || pop_cnt != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_end: got line=%b busy=%b done=%b pops=%0d left=%0d, required 10/0/0/0/0",
                     {d_plus, d_minus}, tx_busy, tx_done, pop_cnt, exp_q.size());
        end
    endtask

    task automatic run_pkt(input logic [3:0] pid, input int nb, input logic [7:0] b0,
                           input logic [7:0] b1, input int exp_stuffs, input string name);
        int n;
        int exp_len;
        fifo_q.delete();
        if (nb > 0) fifo_q.push_back(b0);
        if (nb > 1) fifo_q.push_back(b1);
        pop_cnt = 0; pop_cyc.delete(); rx_stuffs = 0; rx_errs = 0;
        exp_len = (19 + 8 * nb + exp_stuffs) * CPB;
        repeat (2) @(negedge clk);
        tx_pid = pid; tx_start = 1'b1;
        exp_q.push_back(8'h80); exp_q.push_back({~pid, pid});
        if (nb > 0) exp_q.push_back(b0);
        if (nb > 1) exp_q.push_back(b1);
        @(negedge clk);
        tx_start = 1'b0;
        n = 1;
        while (n < 3000 && tx_done !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != exp_len) begin
            miscompares++;
            $display("FAIL %s_length: done at cycle %0d, required %0d", name, n, exp_len);
        end
        @(negedge clk);
        vectors++;
        if (pop_cnt != nb || rx_stuffs != exp_stuffs || rx_errs != 0 || exp_q.size() != 0 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_summary: pops=%0d stuffs=%0d errs=%0d left=%0d busy=%b, required %0d/%0d/0/0/0",
                     name, pop_cnt, rx_stuffs, rx_errs, exp_q.size(), tx_busy, nb, exp_stuffs);
        end
        exp_q.delete();
    endtask

    task automatic test_payloads;
        int gap;
        run_pkt(4'b0001, 1, 8'hC9, 8'h00, 0, "data_c9");
        run_pkt(4'b0001, 1, 8'h3F, 8'h00, 1, "stuff_3f");
        run_pkt(4'b0001, 2, 8'hFF, 8'hFF, 3, "stuff_ffff");
        gap = (pop_cyc.size() == 2) ? pop_cyc[1] - pop_cyc[0] : -1;
        vectors++;
        if (gap != 72 && gap != 80) begin
            miscompares++;
            $display("FAIL pop_spacing: got %0d, required 72 or 80", gap);
        end
        run_pkt(4'b1001, 1, 8'h00, 8'h00, 0, "data_00");
    endtask

    task automatic test_back_to_back_start;
        int n;
        int dones;
        int late_busy;
        fifo_q.delete(); fifo_q.push_back(8'h55);
        rx_errs = 0; dones = 0; late_busy = 0;
        repeat (2) @(negedge clk);
        tx_pid = 4'b0001; tx_start = 1'b1;
        exp_q.push_back(8'h80); exp_q.push_back(8'hE1); exp_q.push_back(8'h55);
        @(negedge clk);
        tx_pid = 4'b1010;
        n = 1;
        while (n < 3000 && dones == 0) begin
            if (tx_done === 1'b1) begin
                dones++;
                tx_start = 1'b0;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        tx_start = 1'b0;
        vectors++;
        if (n != 216) begin
            miscompares++;
            $display("FAIL restart_length: done at cycle %0d, required 216", n);
        end
        repeat (30) begin
            @(negedge clk);
            if (tx_done === 1'b1) dones++;
            if (tx_busy !== 1'b0) late_busy++;
        end
        vectors++;
        if (dones != 1 || late_busy != 0 || exp_q.size() != 0 || rx_errs != 0) begin
            miscompares++;
            $display("FAIL restart_ignore: dones=%0d late_busy=%0d left=%0d errs=%0d, required 1/0/0/0",
                     dones, late_busy, exp_q.size(), rx_errs);
        end
        exp_q.delete();
    endtask

    task automatic test_mid_reset;
        int bad_line;
        int bad_busy;
        fifo_q.delete(); fifo_q.push_back(8'hA5); fifo_q.push_back(8'h5A);
        repeat (2) @(negedge clk);
        tx_pid = 4'b0011; tx_start = 1'b1;
        exp_q.push_back(8'h80); exp_q.push_back(8'hC3); exp_q.push_back(8'hA5);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (140) @(negedge clk);
        rst = 1'b1; tx_start = 1'b1;
        @(negedge clk);
        vectors++;
        if ({d_plus, d_minus, tx_busy, tx_done, tx_r_enable} !== {LJ, 3'b000}) begin
            miscompares++;
            $display("FAIL mid_reset_edge: got %b, required %b",
                     {d_plus, d_minus, tx_busy, tx_done, tx_r_enable}, {LJ, 3'b000});
        end
        @(negedge clk);
        rst = 1'b0; tx_start = 1'b0;
        exp_q.delete();
        pop_cnt = 0; bad_line = 0; bad_busy = 0;
        vectors++;
        if ({d_plus, d_minus} !== LJ || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_after: got line=%b busy=%b, required 10/0", {d_plus, d_minus}, tx_busy);
        end
        repeat (200) begin
            @(negedge clk);
            if ({d_plus, d_minus} !== LJ) bad_line++;
            if (tx_busy !== 1'b0) bad_busy++;
        end
        vectors++;
        if (pop_cnt != 0 || bad_line != 0 || bad_busy != 0) begin
            miscompares++;
            $display("FAIL mid_reset_quiet: pops=%0d bad_line=%0d bad_busy=%0d, required 0/0/0",
                     pop_cnt, bad_line, bad_busy);
        end
        fifo_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic_lines();
        test_payloads();
        test_back_to_back_start();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within 60000 cycles");
        $fatal(1);
    end

endmodule
